// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier front-end arbiter.
package booth_pkg;

  localparam int unsigned BOOTH_W       = 4;
  localparam int unsigned BOOTH_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/booth_arb_rr_arb2.sv
// Two-way round-robin grant. prio_q names the requester that wins a tie;
// it flips to the other requester whenever a transaction completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    prio_d = prio_q;
    if (upd_i) prio_d = ~last_i;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/booth_arb.sv
// Arbitrates two requesters onto one shared sequential Booth multiplier.
//   state | meaning
//   IDLE  | waiting for a request; grants one and latches its operands
//   LOAD  | mul_reset pulse loads the latched operands into the multiplier
//   RUN   | counting cycles until mul_endflag or timeout
//   RESP  | holding the result for the granted requester until it is consumed
module booth_arb
  import booth_pkg::*;
#(
  parameter int unsigned TIMEOUT = BOOTH_TIMEOUT,
  parameter int unsigned W       = BOOTH_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_p,
  output logic           rsp_err,
  output logic           mul_reset,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_endflag,
  input  logic [2*W-1:0] mul_product
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;
  logic           err_q, err_d;

  logic [1:0]     gnt;
  logic [1:0]     rdy;
  logic           upd;
  logic [CW-1:0]  cnt_inc;

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_i  ({req1_valid, req0_valid}),
    .last_i (id_q),
    .upd_i  (upd),
    .gnt_o  (gnt)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    err_d   = err_q;
    rdy     = 2'b00;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          rdy     = gnt;
          id_d    = gnt[1];
          a_d     = gnt[1] ? req1_a : req0_a;
          b_d     = gnt[1] ? req1_b : req0_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        // The multiplier is still settling from the load in the first RUN cycle.
        if (cnt_q != '0 && mul_endflag) begin
          p_d     = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_inc == TO_C) begin
          p_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (id_q ? rsp1_ready : rsp0_ready) begin
          upd     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready = rdy[0] & ~reset;
  assign req1_ready = rdy[1] & ~reset;
  assign rsp0_valid = (state_q == RESP) & ~id_q & ~reset;
  assign rsp1_valid = (state_q == RESP) &  id_q & ~reset;
  assign rsp_p      = p_q;
  assign rsp_err    = err_q;
  assign mul_reset  = reset | (state_q == LOAD);
  assign mul_a      = a_q;
  assign mul_b      = b_q;

endmodule

// File: doc/booth_arb.md
BOOTH_ARB -- requirements
Module: booth_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum RUN-state cycles to wait for mul_endflag.
REQ-002 SHALL have parameter W, default 4: operand width; the product is 2*W bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operand pair pending.
REQ-006 req0_ready / req1_ready  output  1  operand pair of requester n accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  W  signed operands of requester n (a multiplicand, b multiplier).
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester n available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester n consumes its result.
REQ-010 rsp_p  output  2W  product, shared by both response channels.
REQ-011 rsp_err  output  1  current response ended by timeout.
REQ-012 mul_reset  output  1  load/restart strobe to the shared Booth multiplier.
REQ-013 mul_a, mul_b  output  W  operands presented to the multiplier.
REQ-014 mul_endflag  input  1  multiplier finished.
REQ-015 mul_product  input  2W  multiplier result, valid while mul_endflag=1.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, RUN and RESP.
REQ-017 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready for exactly that cycle, latch its operands, and go to LOAD.
REQ-018 Arbitration SHALL be round-robin: with both requesters valid, the one not served last wins; after reset requester 0 has priority.
REQ-019 LOAD: mul_reset SHALL be 1 for exactly one cycle, with mul_a/mul_b driving the latched operands; next state is RUN.
REQ-020 mul_a/mul_b SHALL hold the latched operands from LOAD through RESP.
REQ-021 RUN: the cycle counter SHALL increment each cycle.
REQ-022 RUN: mul_endflag SHALL be ignored in the first RUN cycle.
REQ-023 RUN: on mul_endflag=1 the block SHALL capture mul_product into rsp_p, set rsp_err=0, and go to RESP.
REQ-024 RUN: if the counter reaches TIMEOUT without mul_endflag, the block SHALL set rsp_p=0, set rsp_err=1, and go to RESP.
REQ-025 RESP: rspN_valid SHALL be 1 only for the granted requester, and SHALL hold with rsp_p and rsp_err stable until rspN_ready=1.
REQ-026 RESP: on the handshake cycle the block SHALL update the round-robin pointer and return to IDLE.
REQ-027 The block SHALL accept no new request outside IDLE; both reqN_ready SHALL be 0 in LOAD, RUN and RESP.
REQ-028 Minimum latency from req handshake to rsp_valid SHALL be 3 cycles, plus the multiplier run time.
REQ-029 A request arriving in the RESP handshake cycle SHALL be granted in the following IDLE cycle.
REQ-030 rspN_ready asserted while rspN_valid=0 SHALL have no effect.

Reset
REQ-031 reset=1 SHALL force: state IDLE, pointer to requester 0, counter 0, all reqN_ready/rspN_valid 0, rsp_p 0, rsp_err 0, mul_a/mul_b 0.
REQ-032 reset=1 SHALL also force mul_reset=1, so the shared multiplier is reinitialised.
REQ-033 A reset in any state mid-operation SHALL abandon the transaction; no response is issued.

Structure
REQ-034 A shared package booth_pkg SHALL hold the state enum, W, and the TIMEOUT default.
REQ-035 Round-robin grant logic SHALL be a sub-module rr_arb2, with inputs req[1:0], last-served pointer and update strobe, and output one-hot gnt[1:0].

Verification
REQ-036 req0 a=4'h3, b=4'h5; model returns endflag after 4 cycles -> rsp0_valid, rsp_p=8'h0F, rsp_err=0.
REQ-037 req0 a=4'hE (-2), b=4'h3 -> rsp_p=8'hFA, and mul_reset was high for exactly one cycle.
REQ-038 req0 and req1 valid in the same cycle, repeated twice -> grant order req0, req1, req0, req1.
REQ-039 mul_endflag held 0 -> after TIMEOUT=15 RUN cycles, rsp_valid=1, rsp_err=1, rsp_p=8'h00.
REQ-040 rsp1_ready held 0 for 10 cycles in RESP -> rsp1_valid, rsp_p and rsp_err stable, req0_ready stays 0.
REQ-041 reset pulsed in RUN -> next cycle state IDLE, all valids 0, no response, mul_reset=1 during the reset.
